// File: rtl/axi4full_burst_sram.sv
// axi4full_burst_sram: AXI4 burst slave over a byte-strobed SRAM with independent read and write FSMs
module axi4full_burst_sram #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH = 4,
  parameter int DEPTH_LOG2 = 12,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 'h8000_0000
) (
  input  logic                    i_aclk,
  input  logic                    i_arsetn,
  input  logic [ID_WIDTH-1:0]     i_awid,
  input  logic [ADDR_WIDTH-1:0]   i_awaddr,
  input  logic [7:0]              i_awlen,
  input  logic [2:0]              i_awsize,
  input  logic [1:0]              i_awburst,
  input  logic                    i_awvalid,
  output logic                    o_awready,
  input  logic [DATA_WIDTH-1:0]   i_wdata,
  input  logic [DATA_WIDTH/8-1:0] i_wstrb,
  input  logic                    i_wlast,
  input  logic                    i_wvalid,
  output logic                    o_wready,
  output logic [ID_WIDTH-1:0]     o_bid,
  output logic [1:0]              o_bresp,
  output logic                    o_bvalid,
  input  logic                    i_bready,
  input  logic [ID_WIDTH-1:0]     i_arid,
  input  logic [ADDR_WIDTH-1:0]   i_araddr,
  input  logic [7:0]              i_arlen,
  input  logic [2:0]              i_arsize,
  input  logic [1:0]              i_arburst,
  input  logic                    i_arvalid,
  output logic                    o_arready,
  output logic [ID_WIDTH-1:0]     o_rid,
  output logic [DATA_WIDTH-1:0]   o_rdata,
  output logic [1:0]              o_rresp,
  output logic                    o_rlast,
  output logic                    o_rvalid,
  input  logic                    i_rready
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam logic [2:0] SZ_MAX = 3'($clog2(BYTES));
  typedef enum logic {R_IDLE, R_BURST} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  logic [DATA_WIDTH-1:0] mem [2**DEPTH_LOG2];
  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a, input logic [7:0] len,
                                                       input logic [2:0] size, input logic [1:0] burst);
    logic [ADDR_WIDTH-1:0] inc, msk;
    inc = ADDR_WIDTH'(1) << size;
    msk = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
    return burst == 2'b00 ? a : burst == 2'b10 ? (a & ~msk) | ((a + inc) & msk) : a + inc;
  endfunction
  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] off;
    off = a - BASE_ADDR;
    return a >= BASE_ADDR && (off >> (DEPTH_LOG2 + int'(SZ_MAX))) == '0;
  endfunction
  function automatic logic [DEPTH_LOG2-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
    return DEPTH_LOG2'((a - BASE_ADDR) >> SZ_MAX);
  endfunction
  r_state_e r_state_q, r_state_d;
  w_state_e w_state_q, w_state_d;
  logic [ID_WIDTH-1:0] r_id_q, r_id_d, w_id_q, w_id_d;
  logic [ADDR_WIDTH-1:0] r_addr_q, r_addr_d, w_addr_q, w_addr_d;
  logic [7:0] r_len_q, r_len_d, w_len_q, w_len_d, r_cnt_q, r_cnt_d, w_cnt_q, w_cnt_d;
  logic [2:0] r_size_q, r_size_d, w_size_q, w_size_d;
  logic [1:0] r_burst_q, r_burst_d, w_burst_q, w_burst_d;
  logic w_err_q, w_err_d, r_ok, w_ok, w_we;
  assign r_ok = in_range(r_addr_q);
  assign w_ok = in_range(w_addr_q);
  assign o_arready = r_state_q == R_IDLE;
  assign o_rvalid = r_state_q == R_BURST;
  assign o_rlast = o_rvalid && r_cnt_q == r_len_q;
  assign o_rid = r_id_q;
  assign o_rresp = o_rvalid && (!r_ok || r_burst_q == 2'b11) ? 2'b10 : 2'b00;
  assign o_rdata = o_rvalid && r_ok ? mem[word_idx(r_addr_q)] : '0;
  assign o_awready = w_state_q == W_IDLE;
  assign o_wready = w_state_q == W_DATA;
  assign o_bvalid = w_state_q == W_RESP;
  assign o_bid = w_id_q;
  assign o_bresp = {w_err_q, 1'b0};
  assign w_we = i_arsetn && o_wready && i_wvalid && w_ok;
  always_comb begin
    r_state_d = r_state_q;
    r_id_d = r_id_q;
    r_addr_d = r_addr_q;
    r_len_d = r_len_q;
    r_size_d = r_size_q;
    r_burst_d = r_burst_q;
    r_cnt_d = r_cnt_q;
    if (r_state_q == R_IDLE && i_arvalid) begin
      r_id_d = i_arid;
      r_addr_d = i_araddr;
      r_len_d = i_arlen;
      r_size_d = i_arsize > SZ_MAX ? SZ_MAX : i_arsize;
      r_burst_d = i_arburst;
      r_cnt_d = '0;
      r_state_d = R_BURST;
    end else if (o_rvalid && i_rready) begin
      r_addr_d = next_addr(r_addr_q, r_len_q, r_size_q, r_burst_q);
      r_cnt_d = r_cnt_q + 8'd1;
      r_state_d = o_rlast ? R_IDLE : R_BURST;
    end
  end
  always_comb begin
    w_state_d = w_state_q;
    w_id_d = w_id_q;
    w_addr_d = w_addr_q;
    w_len_d = w_len_q;
    w_size_d = w_size_q;
    w_burst_d = w_burst_q;
    w_cnt_d = w_cnt_q;
    w_err_d = w_err_q;
    if (w_state_q == W_IDLE && i_awvalid) begin
      w_id_d = i_awid;
      w_addr_d = i_awaddr;
      w_len_d = i_awlen;
      w_size_d = i_awsize > SZ_MAX ? SZ_MAX : i_awsize;
      w_burst_d = i_awburst;
      w_cnt_d = '0;
      w_err_d = i_awburst == 2'b11;
      w_state_d = W_DATA;
    end else if (o_wready && i_wvalid) begin
      w_addr_d = next_addr(w_addr_q, w_len_q, w_size_q, w_burst_q);
      w_cnt_d = w_cnt_q + 8'd1;
      w_err_d = w_err_q | !w_ok | (i_wlast != (w_cnt_q == w_len_q));
      w_state_d = w_cnt_q == w_len_q ? W_RESP : W_DATA;
    end else if (o_bvalid && i_bready) begin
      w_state_d = W_IDLE;
    end
  end
  always_ff @(posedge i_aclk) begin
    if (!i_arsetn) begin
      r_state_q <= R_IDLE;
      w_state_q <= W_IDLE;
      r_id_q <= '0;
      r_addr_q <= '0;
      r_len_q <= '0;
      r_size_q <= '0;
      r_burst_q <= '0;
      r_cnt_q <= '0;
      w_id_q <= '0;
      w_addr_q <= '0;
      w_len_q <= '0;
      w_size_q <= '0;
      w_burst_q <= '0;
      w_cnt_q <= '0;
      w_err_q <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      w_state_q <= w_state_d;
      r_id_q <= r_id_d;
      r_addr_q <= r_addr_d;
      r_len_q <= r_len_d;
      r_size_q <= r_size_d;
      r_burst_q <= r_burst_d;
      r_cnt_q <= r_cnt_d;
      w_id_q <= w_id_d;
      w_addr_q <= w_addr_d;
      w_len_q <= w_len_d;
      w_size_q <= w_size_d;
      w_burst_q <= w_burst_d;
      w_cnt_q <= w_cnt_d;
      w_err_q <= w_err_d;
    end
  end
  // Array has no reset so contents survive a mid-burst reset
  always_ff @(posedge i_aclk) begin
    if (w_we)
      for (int b = 0; b < BYTES; b++)
        if (i_wstrb[b]) mem[word_idx(w_addr_q)][8*b +: 8] <= i_wdata[8*b +: 8];
  end
endmodule

// File: tb/tb_axi4full_burst_sram.sv
// tb_axi4full_burst_sram: directed bench for the AXI4 burst SRAM
module tb_axi4full_burst_sram;
  logic clk = 1'b0;
  logic i_arsetn;
  logic [3:0] i_awid, i_arid, o_bid, o_rid;
  logic [31:0] i_awaddr, i_araddr;
  logic [7:0] i_awlen, i_arlen, i_wstrb;
  logic [2:0] i_awsize, i_arsize;
  logic [1:0] i_awburst, i_arburst, o_bresp, o_rresp;
  logic i_awvalid, o_awready, i_wlast, i_wvalid, o_wready, o_bvalid, i_bready;
  logic i_arvalid, o_arready, o_rlast, o_rvalid, i_rready;
  logic [63:0] i_wdata, o_rdata;
  logic [63:0] wd [16];
  logic [63:0] rexp [16];
  int errors = 0;
  int checks = 0;

  axi4full_burst_sram dut (
    .i_aclk(clk), .i_arsetn(i_arsetn),
    .i_awid(i_awid), .i_awaddr(i_awaddr), .i_awlen(i_awlen), .i_awsize(i_awsize),
    .i_awburst(i_awburst), .i_awvalid(i_awvalid), .o_awready(o_awready),
    .i_wdata(i_wdata), .i_wstrb(i_wstrb), .i_wlast(i_wlast), .i_wvalid(i_wvalid), .o_wready(o_wready),
    .o_bid(o_bid), .o_bresp(o_bresp), .o_bvalid(o_bvalid), .i_bready(i_bready),
    .i_arid(i_arid), .i_araddr(i_araddr), .i_arlen(i_arlen), .i_arsize(i_arsize),
    .i_arburst(i_arburst), .i_arvalid(i_arvalid), .o_arready(o_arready),
    .o_rid(o_rid), .o_rdata(o_rdata), .o_rresp(o_rresp), .o_rlast(o_rlast), .o_rvalid(o_rvalid),
    .i_rready(i_rready)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input string nm, input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                    input logic [1:0] burst, input logic [7:0] strb, input logic [1:0] bresp_exp,
                    input bit bad_last, input int bstall);
    int n;
    i_awid = id; i_awaddr = addr; i_awlen = len; i_awsize = 3'd3; i_awburst = burst; i_awvalid = 1'b1;
    n = 0;
    while (!o_awready && n < 16) begin tick; n++; end
    checks++;
    if (o_awready !== 1'b1) begin errors++; $display("FAIL %s awready got %b want 1", nm, o_awready); end
    tick;
    i_awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      i_wdata = wd[i]; i_wstrb = strb; i_wvalid = 1'b1;
      i_wlast = bad_last ? (i == 0) : (i == int'(len));
      n = 0;
      while (!o_wready && n < 16) begin tick; n++; end
      checks++;
      if (o_wready !== 1'b1) begin errors++; $display("FAIL %s beat %0d wready got %b want 1", nm, i, o_wready); end
      tick;
    end
    i_wvalid = 1'b0; i_wlast = 1'b0;
    for (int k = 0; k < bstall; k++) begin
      checks++;
      if (o_bvalid !== 1'b1) begin errors++; $display("FAIL %s stall %0d bvalid got %b want 1", nm, k, o_bvalid); end
      tick;
    end
    i_bready = 1'b1;
    n = 0;
    while (!o_bvalid && n < 16) begin tick; n++; end
    checks++;
    if (o_bresp !== bresp_exp || o_bvalid !== 1'b1)
      begin errors++; $display("FAIL %s bresp got %b/%b want %b/1", nm, o_bresp, o_bvalid, bresp_exp); end
    checks++;
    if (o_bid !== id) begin errors++; $display("FAIL %s bid got %h want %h", nm, o_bid, id); end
    tick;
    i_bready = 1'b0;
    checks++;
    if (o_bvalid !== 1'b0) begin errors++; $display("FAIL %s bvalid after B got %b want 0", nm, o_bvalid); end
  endtask

  task automatic rd(input string nm, input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                    input logic [2:0] size, input logic [1:0] burst, input logic [1:0] resp_exp,
                    input bit chk_data, input int stall_at, input int stall_n);
    int n;
    i_arid = id; i_araddr = addr; i_arlen = len; i_arsize = size; i_arburst = burst; i_arvalid = 1'b1;
    n = 0;
    while (!o_arready && n < 16) begin tick; n++; end
    checks++;
    if (o_arready !== 1'b1) begin errors++; $display("FAIL %s arready got %b want 1", nm, o_arready); end
    tick;
    i_arvalid = 1'b0; i_rready = 1'b1;
    for (int i = 0; i <= int'(len); i++) begin
      n = 0;
      while (!o_rvalid && n < 16) begin tick; n++; end
      checks++;
      if (o_rvalid !== 1'b1) begin errors++; $display("FAIL %s beat %0d rvalid got %b want 1", nm, i, o_rvalid); end
      if (chk_data) begin
        checks++;
        if (o_rdata !== rexp[i]) begin errors++; $display("FAIL %s beat %0d rdata got %h want %h", nm, i, o_rdata, rexp[i]); end
      end
      checks++;
      if (o_rresp !== resp_exp) begin errors++; $display("FAIL %s beat %0d rresp got %b want %b", nm, i, o_rresp, resp_exp); end
      checks++;
      if (o_rlast !== (i == int'(len))) begin errors++; $display("FAIL %s beat %0d rlast got %b want %b", nm, i, o_rlast, i == int'(len)); end
      checks++;
      if (o_rid !== id) begin errors++; $display("FAIL %s beat %0d rid got %h want %h", nm, i, o_rid, id); end
      if (i == stall_at) begin
        i_rready = 1'b0;
        for (int k = 0; k < stall_n; k++) begin
          tick;
          checks++;
          if (o_rvalid !== 1'b1 || o_rdata !== rexp[i] || o_rlast !== (i == int'(len)))
            begin errors++; $display("FAIL %s stall %0d rvalid/rdata/rlast got %b/%h/%b want 1/%h/%b", nm, k, o_rvalid, o_rdata, o_rlast, rexp[i], i == int'(len)); end
        end
        i_rready = 1'b1;
      end
      tick;
    end
    i_rready = 1'b0;
    checks++;
    if (o_rvalid !== 1'b0) begin errors++; $display("FAIL %s rvalid after burst got %b want 0", nm, o_rvalid); end
  endtask

  task automatic test_reset;
    i_arsetn = 1'b0;
    tick;
    tick;
    checks++;
    if (o_rvalid !== 1'b0 || o_bvalid !== 1'b0 || o_rlast !== 1'b0 || o_wready !== 1'b0)
      begin errors++; $display("FAIL reset valids got r%b b%b l%b w%b want all 0", o_rvalid, o_bvalid, o_rlast, o_wready); end
    checks++;
    if (o_rid !== 4'h0 || o_bid !== 4'h0 || o_rresp !== 2'b00 || o_bresp !== 2'b00)
      begin errors++; $display("FAIL reset ids/resps got %h %h %b %b want 0", o_rid, o_bid, o_rresp, o_bresp); end
    i_arsetn = 1'b1;
    tick;
    checks++;
    if (o_awready !== 1'b1 || o_arready !== 1'b1)
      begin errors++; $display("FAIL reset readies got aw%b ar%b want 1 1", o_awready, o_arready); end
  endtask

  task automatic test_incr;
    wd[0] = 64'h11; wd[1] = 64'h22; wd[2] = 64'h33; wd[3] = 64'h44;
    wr("incr_wr", 4'h5, 32'h8000_0000, 8'd3, 2'b01, 8'hFF, 2'b00, 1'b0, 0);
    rexp[0] = 64'h11; rexp[1] = 64'h22; rexp[2] = 64'h33; rexp[3] = 64'h44;
    rd("incr_rd", 4'h3, 32'h8000_0000, 8'd3, 3'd3, 2'b01, 2'b00, 1'b1, -1, 0);
  endtask

  task automatic test_wrap;
    rexp[0] = 64'h33; rexp[1] = 64'h44; rexp[2] = 64'h11; rexp[3] = 64'h22;
    rd("wrap_rd", 4'h9, 32'h8000_0010, 8'd3, 3'd3, 2'b10, 2'b00, 1'b1, -1, 0);
  endtask

  task automatic test_strobes;
    wd[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    wr("strb_full", 4'h1, 32'h8000_0100, 8'd0, 2'b01, 8'hFF, 2'b00, 1'b0, 0);
    wd[0] = 64'h0;
    wr("strb_low", 4'h2, 32'h8000_0100, 8'd0, 2'b01, 8'h0F, 2'b00, 1'b0, 0);
    rexp[0] = 64'hFFFF_FFFF_0000_0000;
    rd("strb_rd", 4'h2, 32'h8000_0100, 8'd0, 3'd3, 2'b01, 2'b00, 1'b1, -1, 0);
  endtask

  task automatic test_out_of_range;
    rexp[0] = 64'h0; rexp[1] = 64'h0;
    rd("oor_rd", 4'h4, 32'h7FFF_FFF8, 8'd1, 3'd3, 2'b00, 2'b10, 1'b1, -1, 0);
    wd[0] = 64'hDEAD_BEEF_0000_0001; wd[1] = 64'hDEAD_BEEF_0000_0002;
    wr("oor_wr", 4'h6, 32'h7FFF_FFF8, 8'd1, 2'b00, 8'hFF, 2'b10, 1'b0, 0);
    rexp[0] = 64'h11;
    rd("oor_intact", 4'h4, 32'h8000_0000, 8'd0, 3'd3, 2'b01, 2'b00, 1'b1, -1, 0);
  endtask

  task automatic test_reserved_and_clamp;
    rd("rsvd_rd", 4'h7, 32'h8000_0000, 8'd1, 3'd3, 2'b11, 2'b10, 1'b0, -1, 0);
    rexp[0] = 64'h11; rexp[1] = 64'h22;
    rd("clamp_rd", 4'h8, 32'h8000_0000, 8'd1, 3'd7, 2'b01, 2'b00, 1'b1, -1, 0);
  endtask

  task automatic test_wlast_mismatch;
    wd[0] = 64'hA; wd[1] = 64'hB;
    wr("wlast_bad", 4'hA, 32'h8000_0200, 8'd1, 2'b01, 8'hFF, 2'b10, 1'b1, 0);
  endtask

  task automatic test_backpressure;
    rexp[0] = 64'h11; rexp[1] = 64'h22; rexp[2] = 64'h33; rexp[3] = 64'h44;
    rd("r_stall", 4'hB, 32'h8000_0000, 8'd3, 3'd3, 2'b01, 2'b00, 1'b1, 1, 5);
    wd[0] = 64'h5555;
    wr("b_stall", 4'hC, 32'h8000_0300, 8'd0, 2'b01, 8'hFF, 2'b00, 1'b0, 5);
  endtask

  task automatic test_reset_mid;
    int n;
    i_arid = 4'hD; i_araddr = 32'h8000_0000; i_arlen = 8'd7; i_arsize = 3'd3; i_arburst = 2'b01; i_arvalid = 1'b1;
    tick;
    i_arvalid = 1'b0; i_rready = 1'b1;
    n = 0;
    while (!o_rvalid && n < 16) begin tick; n++; end
    checks++;
    if (o_rdata !== 64'h11) begin errors++; $display("FAIL rst_mid beat0 rdata got %h want 11", o_rdata); end
    tick;
    checks++;
    if (o_rdata !== 64'h22 || o_rvalid !== 1'b1) begin errors++; $display("FAIL rst_mid beat1 rdata got %h want 22", o_rdata); end
    i_rready = 1'b0; i_arsetn = 1'b0;
    tick;
    checks++;
    if (o_rvalid !== 1'b0 || o_arready !== 1'b1)
      begin errors++; $display("FAIL rst_mid rvalid/arready got %b/%b want 0/1", o_rvalid, o_arready); end
    i_arsetn = 1'b1;
    tick;
    rexp[0] = 64'h11; rexp[1] = 64'h22; rexp[2] = 64'h33; rexp[3] = 64'h44;
    rd("rst_mid_rd", 4'hE, 32'h8000_0000, 8'd3, 3'd3, 2'b01, 2'b00, 1'b1, -1, 0);
  endtask

  initial begin
    i_arsetn = 1'b0;
    i_awid = '0; i_awaddr = '0; i_awlen = '0; i_awsize = '0; i_awburst = '0; i_awvalid = 1'b0;
    i_wdata = '0; i_wstrb = '0; i_wlast = 1'b0; i_wvalid = 1'b0; i_bready = 1'b0;
    i_arid = '0; i_araddr = '0; i_arlen = '0; i_arsize = '0; i_arburst = '0; i_arvalid = 1'b0; i_rready = 1'b0;
    test_reset;
    test_incr;
    test_wrap;
    test_strobes;
    test_out_of_range;
    test_reserved_and_clamp;
    test_wlast_mismatch;
    test_backpressure;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/axi4full_burst_sram.md
AXI4FULL_BURST_SRAM -- requirements
Module: axi4full_burst_sram

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, data bus width in bits (64 or 32).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, address width in bits.
REQ-003 SHALL have parameter ID_WIDTH, default 4, width of the AXI ID fields.
REQ-004 SHALL have parameter DEPTH_LOG2, default 12, log2 of the number of DATA_WIDTH-bit words in the array.
REQ-005 SHALL have parameter BASE_ADDR, default 32'h8000_0000, byte address of word 0.
REQ-006 SHALL have the following ports, in this order:
- i_aclk, input, 1, the single clock; all logic samples on its rising edge.
- i_arsetn, input, 1, reset; synchronous and active-low.
- AW channel: i_awid (ID_WIDTH), i_awaddr (ADDR_WIDTH), i_awlen (8), i_awsize (3), i_awburst (2), i_awvalid (1) are inputs; o_awready (1) is an output.
- W channel: i_wdata (DATA_WIDTH), i_wstrb (DATA_WIDTH/8), i_wlast (1), i_wvalid (1) are inputs; o_wready (1) is an output.
- B channel: o_bid (ID_WIDTH), o_bresp (2), o_bvalid (1) are outputs; i_bready (1) is an input.
- AR channel: i_arid (ID_WIDTH), i_araddr (ADDR_WIDTH), i_arlen (8), i_arsize (3), i_arburst (2), i_arvalid (1) are inputs; o_arready (1) is an output.
- R channel: o_rid (ID_WIDTH), o_rdata (DATA_WIDTH), o_rresp (2), o_rlast (1), o_rvalid (1) are outputs; i_rready (1) is an input.

Function
REQ-007 SHALL hold an internal array of 2^DEPTH_LOG2 words; word index = (addr - BASE_ADDR) >> log2(DATA_WIDTH/8).
REQ-008 SHALL run independent read and write channels; each accepts one outstanding burst at a time.
REQ-009 Read FSM states: R_IDLE, R_BURST.
- R_IDLE: o_arready=1. An AR handshake (valid & ready) latches id, addr, len, size and burst, clears the beat counter, and moves to R_BURST.
- R_BURST: o_arready=0 and o_rvalid=1 (first beat one cycle after the AR handshake). o_rid equals the latched id.
REQ-010 o_rdata/o_rresp SHALL reflect the current beat address and stay stable while o_rvalid=1 and i_rready=0.
REQ-011 Each R handshake SHALL advance the address and increment the beat counter.
REQ-012 o_rlast SHALL be 1 exactly when beat count == latched len. An R handshake with o_rlast=1 returns the FSM to R_IDLE; no new AR is accepted in that same cycle.
REQ-013 Write FSM states: W_IDLE, W_DATA, W_RESP.
- W_IDLE: o_awready=1; an AW handshake latches the fields and moves to W_DATA.
- W_DATA: o_wready=1; each W handshake writes the byte lanes enabled by i_wstrb.
- The W handshake at beat count == len moves to W_RESP.
- W_RESP: o_bvalid=1 and o_bid equals the latched id, held until i_bready; then back to W_IDLE.
REQ-014 Address advance SHALL depend on the latched burst type:
- FIXED (00): the address is unchanged.
- INCR (01): addr += 1 << size.
- WRAP (10): addr = (addr & ~(B-1)) | ((addr + (1<<size)) & (B-1)), where B = (len+1) << size.
REQ-015 Reserved burst type 11 SHALL be treated as INCR and SHALL return resp SLVERR on every beat.
REQ-016 A beat whose address lies outside [BASE_ADDR, BASE_ADDR + 2^DEPTH_LOG2 * DATA_WIDTH/8) SHALL be handled as follows:
- Read: rresp=2'b10 and rdata=0.
- Write: the beat is discarded.
- Any such beat in a write burst makes bresp=2'b10.
REQ-017 In-range beats SHALL give resp 2'b00 (OKAY).
REQ-018 A mismatch between i_wlast and beat==len SHALL set bresp=2'b10. Burst termination SHALL be governed only by the beat count.
REQ-019 A write and a read to the same word in the same cycle: the read beat SHALL return the pre-write data; the write is visible from the next cycle.
REQ-020 i_awsize/i_arsize larger than log2(DATA_WIDTH/8) SHALL be clamped to that value for address advance.

Reset
REQ-021 While i_arsetn=0 at a rising edge, both FSMs SHALL enter their IDLE states and the outputs SHALL take these values:
- o_rvalid=0, o_bvalid=0, o_rlast=0.
- o_awready=1 and o_arready=1 from the first cycle after reset.
- o_wready=0.
- o_rid, o_bid, o_rresp and o_bresp are 0.
REQ-022 Reset mid-burst SHALL abandon the burst with no further beats or responses. Array contents SHALL be retained; already-written beats stay written.

Verification
REQ-023 INCR write then read: awaddr=0x8000_0000, len=3, size=3, wdata 0x11..0x44 with full strobes -> bresp=00. Readback returns 0x11, 0x22, 0x33, 0x44 with rlast on beat 4 only.
REQ-024 WRAP read: araddr=0x8000_0010, len=3, size=3 -> beat addresses 0x10, 0x18, 0x00, 0x08.
REQ-025 Byte strobes: write 0xFFFF_FFFF_FFFF_FFFF, then write wdata=0 with wstrb=0x0F -> readback 0xFFFF_FFFF_0000_0000.
REQ-026 Out of range: araddr=0x7FFF_FFF8, len=1 -> both beats rresp=10, rdata=0. A write to the same address -> bresp=10 and the array is unchanged.
REQ-027 Backpressure: hold i_rready=0 for 5 cycles mid-burst -> o_rdata/o_rlast stable, no beat lost. Hold i_bready=0 -> o_bvalid stays 1.
REQ-028 Reset on beat 2 of a len=7 read -> o_rvalid=0 on the next cycle and o_arready=1. A subsequent read of earlier-written data returns the correct values.
